// File: rtl/dct_pkg.sv
// dct_pkg: shared types and defaults for the DCT datapath
package dct_pkg;
   typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} tp_bank_e;
   localparam int TP_N = 8;
   localparam int TP_DATA_W = 24;
endpackage

// File: rtl/tp_bank_ram.sv
// tp_bank_ram: one write port, one registered read port
module tp_bank_ram
   import dct_pkg::*;
#(
   parameter int DATA_W = TP_DATA_W,
   parameter int AW = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong N x N transpose between row and column DCT passes
module dct_transpose_buffer
   import dct_pkg::*;
#(
   parameter int DATA_W = TP_DATA_W,
   parameter int N = TP_N
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int AW = $clog2(N*N);
   localparam logic [AW-1:0] LAST = AW'(N*N-1);
   tp_bank_e bank_st [2];
   logic wr_sel, rd_sel, rd_bank, inflight, last_q;
   logic [AW-1:0] wr_cnt, rd_cnt, raddr;
   logic [DATA_W-1:0] rdata [2];
   logic [DATA_W:0] fifo [2];
   logic fifo_wp, fifo_rp;
   logic [1:0] fifo_cnt;
   logic wr_en, rd_en, pop;
   logic [2:0] occ;
   always_comb begin
      in_ready = rst_n && (bank_st[wr_sel] == EMPTY || bank_st[wr_sel] == FILL);
      wr_en = in_valid && in_ready;
      out_valid = fifo_cnt != 2'd0;
      {out_last, out_data} = out_valid ? fifo[fifo_rp] : '0;
      pop = out_valid && out_ready;
      occ = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
      rd_en = (bank_st[rd_sel] == FULL || bank_st[rd_sel] == DRAIN) && occ < 3'd2;
      raddr = AW'((int'(rd_cnt) % N) * N + int'(rd_cnt) / N);
   end
   for (genvar b = 0; b < 2; b++) begin : g_bank
      tp_bank_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
         .clk(clk),
         .we(wr_en && wr_sel == 1'(b)),
         .waddr(wr_cnt),
         .wdata(in_data),
         .re(rd_en && rd_sel == 1'(b)),
         .raddr(raddr),
         .rdata(rdata[b])
      );
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_st <= '{EMPTY, EMPTY};
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
         rd_bank <= 1'b0;
         inflight <= 1'b0;
         last_q <= 1'b0;
         fifo <= '{default: '0};
         fifo_wp <= 1'b0;
         fifo_rp <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (wr_en) begin
            bank_st[wr_sel] <= wr_cnt == LAST ? FULL : FILL;
            wr_sel <= wr_sel ^ (wr_cnt == LAST);
            wr_cnt <= wr_cnt + AW'(1);
         end
         if (rd_en) begin
            bank_st[rd_sel] <= rd_cnt == LAST ? EMPTY : DRAIN;
            rd_sel <= rd_sel ^ (rd_cnt == LAST);
            rd_cnt <= rd_cnt + AW'(1);
         end
         inflight <= rd_en;
         rd_bank <= rd_sel;
         last_q <= rd_cnt == LAST;
         if (inflight) begin
            fifo[fifo_wp] <= {last_q, rdata[rd_bank]};
            fifo_wp <= ~fifo_wp;
         end
         if (pop) fifo_rp <= ~fifo_rp;
         fifo_cnt <= fifo_cnt + 2'(inflight) - 2'(pop);
      end
   end
endmodule
